// File: rtl/button_pulse.sv
// Push-button debouncer producing one registered clock-enable pulse per accepted press.
// Define BUTTON_PULSE_AUTOREPEAT_EN to add auto-repeat pulses while the button stays held.
module button_pulse #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          ACTIVE_LEVEL  = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 20,
  parameter int unsigned REPEAT_PERIOD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic ce_out,
  output logic level
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCheckPress,
    StHeld,
    StCheckRelease
  } state_e;

  if (STABLE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_pulse: STABLE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic            r_s0;
  logic            r_s1;
  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_ce;
  logic            r_level;

  state_e          w_state_next;
  logic [CntW-1:0] w_cnt_next;
  logic            w_press;
  logic            w_level_next;
  logic            w_repeat;

  // Synchronizer; polarity folded in so the FSM always sees 1 as pressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else begin
      r_s0 <= btn_in ^ ~ACTIVE_LEVEL;
      r_s1 <= r_s0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_press      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_s1) begin
          w_state_next = StCheckPress;
          w_cnt_next   = '0;
        end
      end
      StCheckPress: begin
        if (!r_s1) begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
        end else if (r_cnt == CntLast) begin
          w_state_next = StHeld;
          w_cnt_next   = '0;
          w_press      = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      StHeld: begin
        if (!r_s1) begin
          w_state_next = StCheckRelease;
          w_cnt_next   = '0;
        end
      end
      StCheckRelease: begin
        if (r_s1) begin
          w_state_next = StHeld;
          w_cnt_next   = '0;
        end else if (r_cnt == CntLast) begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = StIdle;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign w_level_next = (w_state_next == StHeld) || (w_state_next == StCheckRelease);

`ifdef BUTTON_PULSE_AUTOREPEAT_EN
  localparam int unsigned RcMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RcW   = $clog2(RcMax + 1);
  localparam logic [RcW-1:0] RcDelayLast  = RcW'(REPEAT_DELAY - 1);
  localparam logic [RcW-1:0] RcPeriodLast = RcW'(REPEAT_PERIOD - 1);

  logic [RcW-1:0] r_rc;
  logic           r_rep_phase;
  logic [RcW-1:0] w_rc_next;
  logic           w_rep_phase_next;
  logic           w_repeat_int;

  // r_rep_phase marks that the initial delay has elapsed and the period is now in force.
  always_comb begin
    w_rc_next        = r_rc;
    w_rep_phase_next = r_rep_phase;
    w_repeat_int     = 1'b0;
    if (w_press || (w_state_next == StIdle)) begin
      w_rc_next        = '0;
      w_rep_phase_next = 1'b0;
    end else if ((r_state == StHeld) && (w_state_next == StHeld)) begin
      if (!r_rep_phase) begin
        if (r_rc == RcDelayLast) begin
          w_repeat_int     = 1'b1;
          w_rc_next        = '0;
          w_rep_phase_next = 1'b1;
        end else begin
          w_rc_next = r_rc + 1'b1;
        end
      end else if (r_rc == RcPeriodLast) begin
        w_repeat_int = 1'b1;
        w_rc_next    = '0;
      end else begin
        w_rc_next = r_rc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rc        <= '0;
      r_rep_phase <= 1'b0;
    end else begin
      r_rc        <= w_rc_next;
      r_rep_phase <= w_rep_phase_next;
    end
  end

  assign w_repeat = w_repeat_int;
`else
  assign w_repeat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_ce    <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ce    <= w_press | w_repeat;
      r_level <= w_level_next;
    end
  end

  assign ce_out = r_ce;
  assign level  = r_level;

endmodule

// File: tb/tb_button_pulse.sv
// Directed self-checking bench for button_pulse with STABLE_CYCLES=4.
// Auto-repeat expectations follow BUTTON_PULSE_AUTOREPEAT_EN.
module tb_button_pulse;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic ce_out;
  logic level;
  logic [1:0] r_count;

  int checks = 0;
  int failures = 0;

`ifdef BUTTON_PULSE_AUTOREPEAT_EN
  localparam bit AutoRep = 1'b1;
`else
  localparam bit AutoRep = 1'b0;
`endif

  always #5 clk = ~clk;

  button_pulse #(
    .STABLE_CYCLES(4),
    .ACTIVE_LEVEL (1'b1),
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn_in(btn_in),
    .ce_out(ce_out),
    .level (level)
  );

  // Downstream modulo-4 counter fed by ce_out.
  always_ff @(posedge clk) begin
    if (rst) r_count <= 2'd0;
    else if (ce_out) r_count <= r_count + 2'd1;
  end

  // Expected pulse at edge k after the first pressed edge of a clean press.
  function automatic logic exp_pulse(input int k);
    return (k == 6) || (AutoRep && (k >= 26) && (((k - 26) % 8) == 0));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_idle();
    btn_in = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_in = 1'b0;
    repeat (3) step();
    checks++;
    if (ce_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_ce got=%b want=0", ce_out);
    end
    checks++;
    if (level !== 1'b0) begin
      failures++;
      $display("FAIL reset_level got=%b want=0", level);
    end
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_clean_press();
    btn_in = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      checks++;
      if (ce_out !== exp_pulse(k)) begin
        failures++;
        $display("FAIL clean_ce edge=%0d got=%b want=%b", k, ce_out, exp_pulse(k));
      end
      checks++;
      if (level !== (k >= 6)) begin
        failures++;
        $display("FAIL clean_level edge=%0d got=%b want=%b", k, level, (k >= 6));
      end
    end
    btn_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (ce_out !== 1'b0) begin
        failures++;
        $display("FAIL release_ce edge=%0d got=%b want=0", k, ce_out);
      end
      checks++;
      if (level !== (k < 6)) begin
        failures++;
        $display("FAIL release_level edge=%0d got=%b want=%b", k, level, (k < 6));
      end
    end
  endtask

  task automatic test_glitch();
    for (int len = 2; len <= 3; len++) begin
      for (int k = 0; k < 12; k++) begin
        btn_in = (k < len);
        step();
        checks++;
        if ((ce_out !== 1'b0) || (level !== 1'b0)) begin
          failures++;
          $display("FAIL glitch len=%0d edge=%0d ce=%b level=%b want 0/0", len, k, ce_out, level);
        end
      end
    end
  endtask

  task automatic test_bouncy_press();
    // 1,0,1,0 then steady 1 from edge 4; pulse lands 6 edges later.
    for (int k = 0; k < 20; k++) begin
      btn_in = (k < 4) ? ((k % 2) == 0) : 1'b1;
      step();
      checks++;
      if (ce_out !== (k == 10)) begin
        failures++;
        $display("FAIL bouncy_ce edge=%0d got=%b want=%b", k, ce_out, (k == 10));
      end
      checks++;
      if (level !== (k >= 10)) begin
        failures++;
        $display("FAIL bouncy_level edge=%0d got=%b want=%b", k, level, (k >= 10));
      end
    end
    release_idle();
  endtask

  task automatic test_release_bounce();
    btn_in = 1'b1;
    repeat (10) step();
    // Two-cycle dropout, restore, then clean release at edge 8.
    for (int k = 0; k < 20; k++) begin
      btn_in = (k >= 2) && (k < 8);
      step();
      checks++;
      if (ce_out !== 1'b0) begin
        failures++;
        $display("FAIL relbounce_ce edge=%0d got=%b want=0", k, ce_out);
      end
      checks++;
      if (level !== (k < 14)) begin
        failures++;
        $display("FAIL relbounce_level edge=%0d got=%b want=%b", k, level, (k < 14));
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    btn_in = 1'b1;
    repeat (10) step();
    checks++;
    if (level !== 1'b1) begin
      failures++;
      $display("FAIL midhold_pre_level got=%b want=1", level);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ((ce_out !== 1'b0) || (level !== 1'b0)) begin
      failures++;
      $display("FAIL midhold_reset ce=%b level=%b want 0/0", ce_out, level);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (ce_out !== (k == 6)) begin
        failures++;
        $display("FAIL midhold_ce edge=%0d got=%b want=%b", k, ce_out, (k == 6));
      end
      checks++;
      if (level !== (k >= 6)) begin
        failures++;
        $display("FAIL midhold_level edge=%0d got=%b want=%b", k, level, (k >= 6));
      end
    end
    release_idle();
  endtask

`ifdef BUTTON_PULSE_AUTOREPEAT_EN
  task automatic test_autorepeat();
    btn_in = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step();
      checks++;
      if (ce_out !== exp_pulse(k)) begin
        failures++;
        $display("FAIL autorep_ce edge=%0d got=%b want=%b", k, ce_out, exp_pulse(k));
      end
    end
    btn_in = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if (ce_out !== 1'b0) begin
        failures++;
        $display("FAIL autorep_release_ce edge=%0d got=%b want=0", k, ce_out);
      end
    end
  endtask
`endif

  task automatic test_counter_chain();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst = 1'b1;
    btn_in = 1'b0;
    step();
    rst = 1'b0;
    for (int p = 0; p < 5; p++) begin
      btn_in = 1'b1;
      repeat (10) step();
      btn_in = 1'b0;
      repeat (10) step();
      checks++;
      if (r_count !== exp_cnt[p]) begin
        failures++;
        $display("FAIL chain_count press=%0d got=%0d want=%0d", p, r_count, exp_cnt[p]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    btn_in = 1'b0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_bouncy_press();
    test_release_bounce();
    test_reset_mid_hold();
`ifdef BUTTON_PULSE_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_counter_chain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
